// File: rtl/uart_frame_parser.sv
// Framed write-command parser behind the UART receiver: SOF, ADDR, LEN, payload, XOR checksum.
// Optional error counter (err_count, clr_err_cnt) enabled by UART_FRAME_PARSER_ERR_CNT_EN.
module uart_frame_parser #(
    parameter int          MAX_LEN      = 8,
    parameter logic [7:0]  SOF_BYTE     = 8'hA5,
    parameter int          TIMEOUT_CLKS = 2048
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_done,
    input  logic       wr_ready,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
`ifdef UART_FRAME_PARSER_ERR_CNT_EN
    ,
    input  logic       clr_err_cnt,
    output logic [7:0] err_count
`endif
);
    localparam int          IW    = $clog2(MAX_LEN + 1);
    localparam int          AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX8  = 8'(MAX_LEN);
    localparam logic [15:0] TC_M1 = 16'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {HUNT, ADDR, LEN, DATA, CHK, DRAIN} state_t;

    state_t state, state_nxt;
    logic [7:0]               base, chk;
    logic [IW-1:0]            len, idx;
    logic [MAX_LEN-1:0][7:0]  pbuf;
    logic [15:0]              tcnt;
    logic                     timed, expire, last;
    logic                     ok_nxt, err_nxt;
    logic [1:0]               code_nxt;

    assign timed    = (state == ADDR) || (state == LEN) || (state == DATA) || (state == CHK);
    // Fires on the edge where the count reaches TIMEOUT_CLKS-1; a byte in that cycle wins.
    assign expire   = timed && !rx_done && ((tcnt + 16'd1) == TC_M1);
    assign last     = (idx == len - 1'b1);
    assign busy     = (state != HUNT);
    assign wr_valid = (state == DRAIN);
    assign wr_addr  = base + 8'(idx);
    assign wr_data  = pbuf[idx[AW-1:0]];

    always_comb begin
        state_nxt = state;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = err_code;
        case (state)
            HUNT:  if (rx_done && rx_byte == SOF_BYTE) state_nxt = ADDR;
            ADDR:  if (rx_done) state_nxt = LEN;
            LEN: if (rx_done) begin
                if (rx_byte > MAX8) begin
                    state_nxt = HUNT;
                    err_nxt   = 1'b1;
                    code_nxt  = 2'd1;
                end else if (rx_byte == 8'd0) state_nxt = CHK;
                else                           state_nxt = DATA;
            end
            DATA:  if (rx_done && last) state_nxt = CHK;
            CHK: if (rx_done) begin
                if (rx_byte != chk) begin
                    state_nxt = HUNT;
                    err_nxt   = 1'b1;
                    code_nxt  = 2'd0;
                end else if (len == '0) begin
                    state_nxt = HUNT;
                    ok_nxt    = 1'b1;
                end else state_nxt = DRAIN;
            end
            DRAIN: begin
                if (wr_ready && last) begin
                    state_nxt = HUNT;
                    ok_nxt    = 1'b1;
                end
                // Bytes arriving while draining are dropped, never parsed as SOF.
                if (rx_done) begin
                    err_nxt  = 1'b1;
                    code_nxt = 2'd3;
                end
            end
            default: state_nxt = HUNT;
        endcase
        if (expire) begin
            state_nxt = HUNT;
            err_nxt   = 1'b1;
            code_nxt  = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state     <= state_nxt;
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
            err_code  <= code_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
            chk  <= '0;
            len  <= '0;
            idx  <= '0;
            pbuf <= '0;
            tcnt <= '0;
        end else begin
            if (rx_done || !timed) tcnt <= '0;
            else                   tcnt <= tcnt + 16'd1;
            case (state)
                ADDR: if (rx_done) begin
                    base <= rx_byte;
                    chk  <= rx_byte;
                end
                LEN: if (rx_done && rx_byte <= MAX8) begin
                    len <= rx_byte[IW-1:0];
                    chk <= chk ^ rx_byte;
                    idx <= '0;
                end
                DATA: if (rx_done) begin
                    pbuf[idx[AW-1:0]] <= rx_byte;
                    chk <= chk ^ rx_byte;
                    idx <= idx + 1'b1;
                end
                CHK:   if (rx_done) idx <= '0;
                DRAIN: if (wr_ready) idx <= last ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef UART_FRAME_PARSER_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           err_count <= 8'd0;
        else if (clr_err_cnt)                 err_count <= 8'd0;
        else if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed frames, monitor pops expected writes/pulses.
module tb_uart_frame_parser;
    localparam int TC = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_done = 1'b0;
    logic       wr_ready = 1'b1;
    logic       wr_valid, frame_ok, frame_err, busy;
    logic [7:0] wr_addr, wr_data;
    logic [1:0] err_code;
`ifdef UART_FRAME_PARSER_ERR_CNT_EN
    logic       clr_err_cnt = 1'b0;
    logic [7:0] err_count;
`endif

    uart_frame_parser #(.MAX_LEN(8), .SOF_BYTE(8'hA5), .TIMEOUT_CLKS(TC)) dut (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_done(rx_done),
        .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
`ifdef UART_FRAME_PARSER_ERR_CNT_EN
        , .clr_err_cnt(clr_err_cnt), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_wr_q[$];
    logic [1:0]  exp_err_q[$];
    int          wr_cyc_q[$];
    int          exp_ok = 0;
    int          strobe_cyc = 0;
    int          err_cyc = -1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT presents one.
    always @(negedge clk) if (rst_n) begin
        if (wr_valid && wr_ready) begin
            wr_cyc_q.push_back(cyc);
            if (exp_wr_q.size() == 0) check("wr_unexpected", {wr_addr, wr_data}, 16'h0);
            else check("wr_addr_data", {wr_addr, wr_data}, exp_wr_q.pop_front());
        end
        if (frame_ok) begin
            check("frame_ok_expected", 32'(exp_ok > 0), 32'd1);
            if (exp_ok > 0) exp_ok--;
        end
        if (frame_err) begin
            err_cyc = cyc;
            if (exp_err_q.size() == 0) check("err_unexpected", {30'd0, err_code}, 32'hEE);
            else check("err_code", {30'd0, err_code}, {30'd0, exp_err_q.pop_front()});
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte = b; rx_done = 1'b1; strobe_cyc = cyc;
        @(posedge clk); #1;
        rx_done = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b[]);
        foreach (b[i]) send_byte(b[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int chk_cyc;
        idle(3);
        @(negedge clk);
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pulses", {30'd0, frame_ok, frame_err}, 0);
        check("rst_addr_data", {wr_addr, wr_data}, 0);
        check("rst_err_code", {30'd0, err_code}, 0);
        rst_n = 1'b1;
        idle(2);

        // Basic 2-byte write, consecutive handshakes
        exp_wr_q.push_back(16'h1033); exp_wr_q.push_back(16'h1144); exp_ok++;
        wr_cyc_q.delete();
        send_frame('{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44});
        send_byte(8'h65);
        chk_cyc = strobe_cyc;
        idle(4);
        check("wr_count_t1", wr_cyc_q.size(), 2);
        if (wr_cyc_q.size() == 2) begin
            check("wr_first_latency", wr_cyc_q[0] - chk_cyc, 1);
            check("wr_back_to_back", wr_cyc_q[1] - wr_cyc_q[0], 1);
        end

        // Address wrap
        exp_wr_q.push_back(16'hFF01); exp_wr_q.push_back(16'h0002); exp_ok++;
        send_frame('{8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'hFE});
        idle(4);

        // Bad checksum then a good frame
        exp_err_q.push_back(2'd0);
        send_frame('{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h66});
        idle(4);
        check("busy_after_badchk", 32'(busy), 0);
        exp_wr_q.push_back(16'h1033); exp_wr_q.push_back(16'h1144); exp_ok++;
        send_frame('{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65});
        idle(4);

        // Length too large, then zero-length frame
        exp_err_q.push_back(2'd1);
        send_frame('{8'hA5, 8'h20, 8'h09});
        idle(2);
        check("busy_after_lenerr", 32'(busy), 0);
        exp_ok++;
        send_frame('{8'hA5, 8'h20, 8'h00, 8'h20});
        idle(4);

        // Timeout after 0x33
        exp_err_q.push_back(2'd2);
        err_cyc = -1;
        send_frame('{8'hA5, 8'h10, 8'h02, 8'h33});
        chk_cyc = strobe_cyc;
        for (int i = 0; i < 3 * TC && err_cyc < 0; i++) @(negedge clk);
        check("timeout_seen", 32'(err_cyc >= 0), 1);
        check("timeout_latency", err_cyc - chk_cyc, TC);
        check("timeout_busy", 32'(busy), 0);
        idle(4);

        // Backpressure with overrun during the stall
        wr_ready = 1'b0;
        exp_wr_q.push_back(16'h30AA); exp_wr_q.push_back(16'h31BB); exp_ok++;
        send_frame('{8'hA5, 8'h30, 8'h02, 8'hAA, 8'hBB, 8'h23});
        exp_err_q.push_back(2'd3);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (i == 100) begin rx_byte = 8'hA5; rx_done = 1'b1; end
            else rx_done = 1'b0;
            @(negedge clk);
            if (i % 25 == 0 || i == 299) begin
                check("stall_valid", 32'(wr_valid), 1);
                check("stall_addr_data", {wr_addr, wr_data}, 16'h30AA);
            end
        end
        @(posedge clk); #1; wr_ready = 1'b1;
        idle(5);
        check("busy_after_drain", 32'(busy), 0);

        // Reset mid-frame discards it silently
        send_frame('{8'hA5, 8'h40, 8'h01});
        @(posedge clk); #1; rst_n = 1'b0;
        idle(2); #1;
        check("midreset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        send_frame('{8'h11, 8'h22});
        idle(4);
        check("midreset_idle", 32'(busy), 0);

        check("wr_queue_empty", exp_wr_q.size(), 0);
        check("err_queue_empty", exp_err_q.size(), 0);
        check("ok_outstanding", exp_ok, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
